// File: rtl/md5_pkg.sv
// Shared constants for the MD5 done-queue: unit count, index width,
// Avalon register offsets and readdata bit positions.
package md5_pkg;

   localparam int   NUNITS    = 32;
   localparam int   IDX_W     = 5;
   localparam logic ADDR_POP  = 1'b0;
   localparam logic ADDR_STAT = 1'b1;
   localparam int   VALID_BIT = 31;
   localparam int   OVF_BIT   = 31;

   // Unit index after idx, wrapping from NUNITS-1 back to 0.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(NUNITS - 1)) begin
         return {IDX_W{1'b0}};
      end else begin
         return idx + IDX_W'(1);
      end
   endfunction

endpackage

// File: rtl/md5_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting unit at or
// after i_rr_ptr, searching upward with wrap from NUNITS-1 to 0.
module md5_rr_arbiter
   import md5_pkg::*;
(
   input  logic [NUNITS-1:0] i_req,
   input  logic [IDX_W-1:0]  i_rr_ptr,
   output logic              o_valid,
   output logic [IDX_W-1:0]  o_idx
);

   // base + off reduced modulo NUNITS (off is always < NUNITS).
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int k;
      k = int'(base) + off;
      if (k >= NUNITS) begin
         k = k - NUNITS;
      end else begin
         k = k;
      end
      return IDX_W'(k);
   endfunction

   // Scan from the round-robin pointer and latch the first requester found.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = {IDX_W{1'b0}};
      for (int off = 0; off < NUNITS; off++) begin
         if (!o_valid && i_req[wrap_add(i_rr_ptr, off)]) begin
            o_valid = 1'b1;
            o_idx   = wrap_add(i_rr_ptr, off);
         end else begin
            o_idx   = o_idx;
         end
      end
   end

endmodule

// File: rtl/md5_done_queue.sv
// Done-event queue for the MD5 unit array: captures md5_done rising edges,
// arbitrates pending units into a FIFO of unit indices, and lets software
// pop finished indices over Avalon-MM. irq flags a non-empty queue.
module md5_done_queue
   import md5_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NUNITS-1:0] i_md5_done,
   input  logic [NUNITS-1:0] i_md5_reset,
   input  logic              i_avs_address,
   input  logic              i_avs_read,
   input  logic              i_avs_write,
   input  logic [31:0]       i_avs_writedata,
   output logic [31:0]       o_avs_readdata,
   output logic              o_irq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [NUNITS-1:0] ONE_HOT0 = {{(NUNITS-1){1'b0}}, 1'b1};

   logic [NUNITS-1:0] r_done_q, r_pending;
   logic [NUNITS-1:0] w_rise, w_req, w_grant_vec, w_pending_nxt;
   logic              r_ovf, w_ovf_set;
   logic [IDX_W-1:0]  r_rr_ptr, w_arb_idx;
   logic              w_arb_valid, w_grant, w_push_ok;
   logic              w_flush, w_rd_cmd, w_pop, w_pop_rd, w_stat_rd;
   logic [IDX_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [31:0]       r_readdata, w_pop_word, w_stat_word;
   logic              r_irq;
   logic              w_unused_wd;

   assign w_unused_wd = ^i_avs_writedata[31:1];

   // A unit being reset this cycle must not be granted, so its entry never appears.
   assign w_rise = i_md5_done & ~r_done_q;
   assign w_req  = r_pending & ~i_md5_reset;

   md5_rr_arbiter u_arb (
      .i_req    (w_req),
      .i_rr_ptr (r_rr_ptr),
      .o_valid  (w_arb_valid),
      .o_idx    (w_arb_idx)
   );

   // Read and write in the same cycle: the write wins and the read is dropped.
   assign w_flush     = i_avs_write & (i_avs_address == ADDR_STAT) & i_avs_writedata[0];
   assign w_rd_cmd    = i_avs_read & ~i_avs_write;
   assign w_pop_rd    = w_rd_cmd & (i_avs_address == ADDR_POP);
   assign w_stat_rd   = w_rd_cmd & (i_avs_address == ADDR_STAT);
   assign w_pop       = w_pop_rd & (r_count != {CNT_W{1'b0}});
   assign w_push_ok   = (r_count < CNT_W'(DEPTH)) | w_pop;
   assign w_grant     = w_arb_valid & w_push_ok & ~w_flush;
   assign w_grant_vec = w_grant ? (ONE_HOT0 << w_arb_idx) : {NUNITS{1'b0}};

   // Pending update: unit reset beats a new rise, which beats a grant.
   always_comb begin
      w_pending_nxt = r_pending;
      w_ovf_set     = 1'b0;
      for (int i = 0; i < NUNITS; i++) begin
         if (i_md5_reset[i]) begin
            w_pending_nxt[i] = 1'b0;
         end else if (w_rise[i]) begin
            w_pending_nxt[i] = 1'b1;
            if (r_pending[i] && !w_grant_vec[i]) begin
               w_ovf_set = 1'b1;
            end else begin
               w_ovf_set = w_ovf_set;
            end
         end else if (w_grant_vec[i]) begin
            w_pending_nxt[i] = 1'b0;
         end else begin
            w_pending_nxt[i] = r_pending[i];
         end
      end
   end

   // Queue occupancy after this cycle's flush / push / pop.
   always_comb begin
      if (w_flush) begin
         w_count_nxt = {CNT_W{1'b0}};
      end else if (w_grant && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_grant && w_pop) begin
         w_count_nxt = r_count - CNT_W'(1);
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Readdata words for POP (valid, pre-pop count, head index) and STATUS.
   always_comb begin
      w_pop_word  = 32'h0000_0000;
      w_stat_word = 32'h0000_0000;
      if (r_count != {CNT_W{1'b0}}) begin
         w_pop_word[VALID_BIT] = 1'b1;
         w_pop_word[15:8]      = 8'(r_count);
         w_pop_word[7:0]       = 8'(r_mem[r_rd_ptr]);
      end else begin
         w_pop_word = 32'h0000_0000;
      end
      w_stat_word[OVF_BIT] = r_ovf;
      w_stat_word[15:8]    = 8'(r_count);
      w_stat_word[7:0]     = 8'(DEPTH);
   end

   // Edge capture, pending bits, overflow, arbiter pointer, FIFO pointers and irq.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_done_q  <= {NUNITS{1'b0}};
         r_pending <= {NUNITS{1'b0}};
         r_ovf     <= 1'b0;
         r_rr_ptr  <= {IDX_W{1'b0}};
         r_wr_ptr  <= {PTR_W{1'b0}};
         r_rd_ptr  <= {PTR_W{1'b0}};
         r_count   <= {CNT_W{1'b0}};
         r_irq     <= 1'b0;
      end else begin
         r_done_q  <= i_md5_done;
         r_pending <= w_pending_nxt;
         r_ovf     <= w_flush ? 1'b0 : (r_ovf | w_ovf_set);
         if (w_grant) begin
            r_rr_ptr <= next_idx(w_arb_idx);
         end
         if (w_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
         end else begin
            if (w_grant) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
         end
         r_count <= w_count_nxt;
         r_irq   <= (w_count_nxt != {CNT_W{1'b0}});
      end
   end

   // Registered Avalon read data, held between reads.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_readdata <= 32'h0000_0000;
      end else if (w_pop_rd) begin
         r_readdata <= w_pop_word;
      end else if (w_stat_rd) begin
         r_readdata <= w_stat_word;
      end
   end

   // FIFO storage: the granted unit index lands at the write pointer.
   always_ff @(posedge i_clk) begin
      if (w_grant) begin
         r_mem[r_wr_ptr] <= w_arb_idx;
      end
   end

   assign o_avs_readdata = r_readdata;
   assign o_irq          = r_irq;

endmodule

// File: tb/tb_md5_done_queue.sv
// Self-checking bench for md5_done_queue: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_md5_done_queue;
   import md5_pkg::*;

   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUNITS-1:0] done_v = '0;
   logic [NUNITS-1:0] mrst_v = '0;
   logic              addr = 1'b0;
   logic              rd = 1'b0;
   logic              wr = 1'b0;
   logic [31:0]       wd = 32'h0;
   logic [31:0]       rdata;
   logic              irq;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   md5_done_queue #(.DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_md5_done      (done_v),
      .i_md5_reset     (mrst_v),
      .i_avs_address   (addr),
      .i_avs_read      (rd),
      .i_avs_write     (wr),
      .i_avs_writedata (wd),
      .o_avs_readdata  (rdata),
      .o_irq           (irq)
   );

   // ---------------- reference model ----------------
   bit          m_pend [NUNITS];
   bit          m_prev [NUNITS];
   int          q [$];
   bit          m_ovf = 1'b0;
   int          m_rr  = 0;
   logic [31:0] m_rd  = 32'h0;
   bit          m_irq = 1'b0;

   task automatic model_step();
      int  sz, win;
      bit  found, grant, pop, flush, rdc, ovf_set, rise;
      if (rst) begin
         foreach (m_pend[i]) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
         q.delete();
         m_ovf = 1'b0; m_rr = 0; m_rd = 32'h0; m_irq = 1'b0;
         return;
      end
      sz    = q.size();
      flush = wr && addr == 1'b1 && wd[0];
      rdc   = rd && !wr;
      pop   = rdc && addr == 1'b0 && sz > 0;
      found = 1'b0; win = 0;
      for (int j = 0; j < NUNITS; j++) begin
         int u;
         u = (m_rr + j) % NUNITS;
         if (!found && m_pend[u] && !mrst_v[u]) begin found = 1'b1; win = u; end
      end
      grant = found && (sz < DEPTH || pop) && !flush;
      if (rdc && addr == 1'b0)
         m_rd = (sz > 0) ? (32'h8000_0000 | (32'(sz) << 8) | 32'(q[0])) : 32'h0;
      else if (rdc && addr == 1'b1)
         m_rd = {m_ovf, 15'd0, 8'(sz), 8'(DEPTH)};
      ovf_set = 1'b0;
      for (int i = 0; i < NUNITS; i++) begin
         rise = done_v[i] && !m_prev[i];
         if (mrst_v[i]) m_pend[i] = 1'b0;
         else if (rise) begin
            if (m_pend[i] && !(grant && win == i)) ovf_set = 1'b1;
            m_pend[i] = 1'b1;
         end else if (grant && win == i) m_pend[i] = 1'b0;
         m_prev[i] = done_v[i];
      end
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (grant) q.push_back(win);
         if (ovf_set) m_ovf = 1'b1;
      end
      if (grant) m_rr = (win + 1) % NUNITS;
      m_irq = (q.size() != 0);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle compare of registered outputs against the model.
   initial forever begin
      @(negedge clk);
      if (chk_on && !rst) begin
         total++;
         if (rdata !== m_rd) begin
            bad++;
            $display("FAIL model_readdata t=%0t: got %h want %h", $time, rdata, m_rd);
         end
         total++;
         if (irq !== m_irq) begin
            bad++;
            $display("FAIL model_irq t=%0t: got %b want %b", $time, irq, m_irq);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read(input logic a, output logic [31:0] d);
      rd = 1'b1; addr = a;
      @(negedge clk);
      d = rdata;
      rd = 1'b0; addr = 1'b0;
   endtask

   task automatic do_write(input logic a, input logic [31:0] v);
      wr = 1'b1; addr = a; wd = v;
      @(negedge clk);
      wr = 1'b0; addr = 1'b0; wd = 32'h0;
   endtask

   task automatic do_reset();
      done_v = '0; mrst_v = '0; rd = 1'b0; wr = 1'b0; wd = 32'h0; addr = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] d;

   initial begin
      cyc(2);
      do_reset();
      chk_on = 1'b1;
      chk("reset_readdata", rdata, 32'h0);
      chk("reset_irq", {31'd0, irq}, 32'd0);

      // 1: single unit, pop, then empty pop
      done_v[5] = 1'b1;
      cyc(2);
      chk("t1_irq_set", {31'd0, irq}, 32'd1);
      cyc(1);
      done_v[5] = 1'b0;
      do_read(1'b0, d); chk("t1_pop", d, 32'h8000_0105);
      do_read(1'b0, d); chk("t1_pop_empty", d, 32'h0);
      chk("t1_irq_clr", {31'd0, irq}, 32'd0);

      // 2: simultaneous rises, then round-robin from pointer 10
      do_reset();
      done_v[3] = 1'b1; done_v[9] = 1'b1;
      cyc(4);
      do_read(1'b0, d); chk("t2_pop3", d, 32'h8000_0203);
      do_read(1'b0, d); chk("t2_pop9", d, 32'h8000_0109);
      done_v[0] = 1'b1; done_v[12] = 1'b1;
      cyc(4);
      do_read(1'b0, d); chk("t2_pop12", d, 32'h8000_020C);
      do_read(1'b0, d); chk("t2_pop0", d, 32'h8000_0100);

      // 3: overfill by two, drain
      do_reset();
      for (int u = 10; u < 20; u++) done_v[u] = 1'b1;
      cyc(12);
      do_read(1'b1, d); chk("t3_status_full", d, 32'h0000_0808);
      for (int i = 0; i < 10; i++) begin
         int cnt;
         cnt = (i <= 2) ? 8 : 10 - i;
         do_read(1'b0, d);
         chk("t3_pop", d, 32'h8000_0000 | (32'(cnt) << 8) | 32'(10 + i));
      end
      do_read(1'b0, d); chk("t3_pop_empty", d, 32'h0);

      // 4: lost event sets overflow, flush clears it
      do_reset();
      for (int u = 0; u < 7; u++) done_v[u] = 1'b1;
      done_v[20] = 1'b1;
      cyc(10);
      do_read(1'b1, d); chk("t4_status_full", d, 32'h0000_0808);
      done_v[7] = 1'b1; cyc(2);
      done_v[7] = 1'b0; cyc(1);
      done_v[7] = 1'b1; cyc(1);
      do_read(1'b1, d); chk("t4_status_ovf", d, 32'h8000_0808);
      do_write(1'b1, 32'h0000_0001);
      do_read(1'b1, d); chk("t4_status_flushed", d, 32'h0000_0008);
      do_write(1'b1, 32'h0000_0000);
      do_read(1'b1, d); chk("t4_write0_noop", d, 32'h0000_0108);
      do_read(1'b0, d); chk("t4_pop7", d, 32'h8000_0107);

      // 5: md5_reset suppresses rise and clears a held pending unit
      do_reset();
      done_v[4] = 1'b1; mrst_v[4] = 1'b1;
      cyc(1);
      mrst_v[4] = 1'b0;
      cyc(3);
      chk("t5_irq_none", {31'd0, irq}, 32'd0);
      do_read(1'b0, d); chk("t5_pop_empty", d, 32'h0);
      for (int u = 20; u < 28; u++) done_v[u] = 1'b1;
      cyc(10);
      done_v[12] = 1'b1;
      cyc(2);
      mrst_v[12] = 1'b1; cyc(1);
      mrst_v[12] = 1'b0; cyc(2);
      for (int i = 0; i < 8; i++) begin
         do_read(1'b0, d);
         chk("t5_pop", d, 32'h8000_0000 | (32'(8 - i) << 8) | 32'(20 + i));
      end
      do_read(1'b0, d); chk("t5_pop_empty2", d, 32'h0);

      // 6: async reset mid-operation
      do_reset();
      done_v[1] = 1'b1; done_v[2] = 1'b1; done_v[3] = 1'b1;
      cyc(5);
      do_read(1'b1, d); chk("t6_status3", d, 32'h0000_0308);
      do_reset();
      chk("t6_irq_after", {31'd0, irq}, 32'd0);
      chk("t6_rd_after", rdata, 32'h0);
      do_read(1'b1, d); chk("t6_status0", d, 32'h0000_0008);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
